// File: rtl/correlation_sequencer_if.sv
// Handshake and bus signals between the correlation sequencer and its datapath/driver.
// The slave side is the sequencer; the master side drives the stream and comparator result.
interface correlation_sequencer_if #(
  parameter int W  = 16,
  parameter int PW = 3
);
  logic          i_start;
  logic          i_stop;
  logic          i_bitIn;
  logic          i_bitValid;
  logic          i_corrHit;
  logic [W-1:0]  o_window;
  logic          o_corrStrobe;
  logic          o_busy;
  logic          o_locked;
  logic [PW-1:0] o_lockPhase;
  logic          o_lockLost;
  logic          o_timeout;

  modport slave (
    input  i_start, i_stop, i_bitIn, i_bitValid, i_corrHit,
    output o_window, o_corrStrobe, o_busy, o_locked, o_lockPhase, o_lockLost, o_timeout
  );

  modport master (
    output i_start, i_stop, i_bitIn, i_bitValid, i_corrHit,
    input  o_window, o_corrStrobe, o_busy, o_locked, o_lockPhase, o_lockLost, o_timeout
  );
endinterface

// File: rtl/correlation_sequencer.sv
// Control FSM for the correlation datapath: fills the oversampled window, strobes the
// shift register / moving average, masks warm-up results, then searches for and tracks a peak.
module correlation_sequencer #(
  parameter int SAMPLES      = 2,
  parameter int OSF          = 8,
  parameter int n            = 3,
  parameter int LOCK_HITS    = 3,
  parameter int MISS_MAX     = 2,
  parameter int SEARCH_LIMIT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  correlation_sequencer_if.slave  bus
);

  localparam int W  = SAMPLES * OSF;
  localparam int PW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int FW = $clog2(W + 1);
  localparam int NW = $clog2(n + 1);
  localparam int SW = $clog2(SEARCH_LIMIT + 1);
  localparam int HW = $clog2(LOCK_HITS + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  typedef enum logic [2:0] {IDLE, FILL, WARMUP, SEARCH, TRACK} state_t;

  state_t        r_state;
  logic [W-1:0]  r_window;
  logic [PW-1:0] r_phaseCnt;
  logic [PW-1:0] r_strobePhase;
  logic [PW-1:0] r_lockPhase;
  logic [FW-1:0] r_fillCnt;
  logic [NW-1:0] r_warmCnt;
  logic [SW-1:0] r_searchCnt;
  logic [HW-1:0] r_hitCnt;
  logic [MW-1:0] r_missCnt;
  logic          r_strobe;
  logic          r_strobeEval;
  logic          r_locked;
  logic          r_lockLost;
  logic          r_timeout;

  logic          w_accept;
  logic          w_eval;
  logic          w_phaseMatch;
  logic [PW-1:0] w_phaseNext;

  assign w_accept     = bus.i_bitValid && (r_state != IDLE);
  assign w_eval       = r_strobe && r_strobeEval;
  assign w_phaseMatch = (r_strobePhase == r_lockPhase);
  assign w_phaseNext  = (r_phaseCnt == PW'(OSF - 1)) ? '0 : r_phaseCnt + PW'(1);

  // Strobes issued from WARMUP/FILL carry r_strobeEval=0, so their comparator result is masked
  // even though the state has already advanced to SEARCH by the time they are evaluated.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_window      <= '0;
      r_phaseCnt    <= '0;
      r_strobePhase <= '0;
      r_lockPhase   <= '0;
      r_fillCnt     <= '0;
      r_warmCnt     <= '0;
      r_searchCnt   <= '0;
      r_hitCnt      <= '0;
      r_missCnt     <= '0;
      r_strobe      <= 1'b0;
      r_strobeEval  <= 1'b0;
      r_locked      <= 1'b0;
      r_lockLost    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_lockLost <= 1'b0;
      r_timeout  <= 1'b0;
      if (bus.i_stop) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
      end else begin
        if (w_accept) begin
          r_window      <= {r_window[W-2:0], bus.i_bitIn};
          r_phaseCnt    <= w_phaseNext;
          r_strobePhase <= r_phaseCnt;
          r_strobeEval  <= (r_state == SEARCH) || (r_state == TRACK);
        end
        case (r_state)
          IDLE: begin
            r_window     <= '0;
            r_phaseCnt   <= '0;
            r_fillCnt    <= '0;
            r_warmCnt    <= '0;
            r_searchCnt  <= '0;
            r_hitCnt     <= '0;
            r_missCnt    <= '0;
            r_strobeEval <= 1'b0;
            r_locked     <= 1'b0;
            if (bus.i_start) r_state <= FILL;
          end
          FILL: begin
            if (w_accept) begin
              r_fillCnt <= r_fillCnt + FW'(1);
              if (r_fillCnt == FW'(W - 1)) begin
                r_strobe  <= 1'b1;
                r_warmCnt <= NW'(1);
                r_state   <= (n <= 1) ? SEARCH : WARMUP;
              end
            end
          end
          WARMUP: begin
            if (w_accept) begin
              r_strobe  <= 1'b1;
              r_warmCnt <= r_warmCnt + NW'(1);
              if (r_warmCnt == NW'(n - 1)) r_state <= SEARCH;
            end
          end
          SEARCH: begin
            r_strobe <= w_accept;
            if (w_eval) begin
              r_searchCnt <= r_searchCnt + SW'(1);
              if (bus.i_corrHit) begin
                r_lockPhase <= r_strobePhase;
                r_hitCnt    <= HW'(1);
                r_missCnt   <= '0;
                r_state     <= TRACK;
              end else if (r_searchCnt == SW'(SEARCH_LIMIT - 1)) begin
                r_timeout <= 1'b1;
                r_strobe  <= 1'b0;
                r_state   <= IDLE;
              end
            end
          end
          TRACK: begin
            r_strobe <= w_accept;
            if (w_eval && w_phaseMatch) begin
              if (bus.i_corrHit) begin
                if (r_hitCnt != HW'(LOCK_HITS)) r_hitCnt <= r_hitCnt + HW'(1);
                r_missCnt <= '0;
                if (r_hitCnt >= HW'(LOCK_HITS - 1)) r_locked <= 1'b1;
              end else if (r_missCnt == MW'(MISS_MAX - 1)) begin
                r_lockLost  <= r_locked;
                r_locked    <= 1'b0;
                r_missCnt   <= '0;
                r_hitCnt    <= '0;
                r_searchCnt <= '0;
                r_state     <= SEARCH;
              end else begin
                r_missCnt <= r_missCnt + MW'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_window     = r_window;
  assign bus.o_corrStrobe = r_strobe;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_locked     = r_locked;
  assign bus.o_lockPhase  = r_lockPhase;
  assign bus.o_lockLost   = r_lockLost;
  assign bus.o_timeout    = r_timeout;

endmodule

// File: tb/tb_correlation_sequencer.sv
// Self-checking bench for correlation_sequencer: random streams against an evaluation-level
// acquisition model (window = last W accepted bits, peaks judged per strobe bit index/phase).
module tb_correlation_sequencer;

  localparam int SAMPLES      = 2;
  localparam int OSF          = 8;
  localparam int NAVG         = 3;
  localparam int LOCK_HITS    = 3;
  localparam int MISS_MAX     = 2;
  localparam int SEARCH_LIMIT = 64;
  localparam int W            = SAMPLES * OSF;
  localparam int PW           = 3;

  logic clk = 1'b0;
  logic reset;

  correlation_sequencer_if #(.W(W), .PW(PW)) bus();

  correlation_sequencer #(
    .SAMPLES(SAMPLES), .OSF(OSF), .n(NAVG), .LOCK_HITS(LOCK_HITS),
    .MISS_MAX(MISS_MAX), .SEARCH_LIMIT(SEARCH_LIMIT)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  bit mQ[$];
  int mK, mStrobeK, mLastEvalK, mLockPh, mSearches, mHits, mMisses;
  bit mRunning, mTracking, mLocked, expLost, expTimeout;

  function automatic logic [W-1:0] expWindow();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (mQ.size() > i) w[i] = mQ[mQ.size() - 1 - i];
    return w;
  endfunction

  function automatic int pendPhase();
    return (mStrobeK > 0) ? (mStrobeK - 1) % OSF : -1;
  endfunction

  // One unmasked peak decision, judged purely by the strobe's phase and the acquisition rules.
  task automatic modelEval(input int phase, input bit hit);
    if (!mTracking) begin
      mSearches++;
      if (hit) begin
        mTracking = 1; mLockPh = phase; mHits = 1; mMisses = 0;
      end else if (mSearches == SEARCH_LIMIT) begin
        expTimeout = 1; mRunning = 0; mLocked = 0;
      end
    end else if (phase == mLockPh) begin
      if (hit) begin
        if (mHits < LOCK_HITS) mHits++;
        mMisses = 0;
        if (mHits >= LOCK_HITS) mLocked = 1;
      end else begin
        mMisses++;
        if (mMisses == MISS_MAX) begin
          expLost = mLocked; mLocked = 0; mTracking = 0; mSearches = 0; mMisses = 0;
        end
      end
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    bus.i_start = 0; bus.i_stop = 0; bus.i_bitValid = 0; bus.i_bitIn = 0; bus.i_corrHit = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    mQ.delete(); mK = 0; mStrobeK = 0; mLastEvalK = 0; mLockPh = 0;
    mSearches = 0; mHits = 0; mMisses = 0;
    mRunning = 0; mTracking = 0; mLocked = 0; expLost = 0; expTimeout = 0;
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit valid, input bit bitIn, input bit hit);
    int sk;
    int newK;
    bus.i_start = start; bus.i_stop = stop; bus.i_bitValid = valid;
    bus.i_bitIn = bitIn; bus.i_corrHit = hit;
    sk = mStrobeK;
    @(posedge clk); #1;
    bus.i_start = 0; bus.i_stop = 0;
    expLost = 0; expTimeout = 0; mLastEvalK = 0;
    if (stop) begin
      mRunning = 0; mLocked = 0; mTracking = 0; mStrobeK = 0;
    end else if (!mRunning) begin
      if (start) begin
        mRunning = 1; mK = 0; mQ.delete(); mTracking = 0;
        mSearches = 0; mHits = 0; mMisses = 0;
      end
      mStrobeK = 0;
    end else begin
      newK = 0;
      if (sk >= W + NAVG) begin
        mLastEvalK = sk;
        modelEval((sk - 1) % OSF, hit);
      end
      if (valid) begin
        mQ.push_back(bitIn);
        mK++;
        if (mK >= W && mRunning) newK = mK;
      end
      mStrobeK = newK;
    end
  endtask

  task automatic test_reset();
    applyReset();
    nChecks++; if (bus.o_window !== '0) begin nFails++; $display("[TB] FAIL reset_window got %h want 0", bus.o_window); end
    nChecks++; if (bus.o_corrStrobe !== 1'b0) begin nFails++; $display("[TB] FAIL reset_strobe got %b want 0", bus.o_corrStrobe); end
    nChecks++; if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", bus.o_busy); end
    nChecks++; if (bus.o_locked !== 1'b0) begin nFails++; $display("[TB] FAIL reset_locked got %b want 0", bus.o_locked); end
    nChecks++; if (bus.o_lockPhase !== '0) begin nFails++; $display("[TB] FAIL reset_lockPhase got %0d want 0", bus.o_lockPhase); end
    nChecks++; if (bus.o_lockLost !== 1'b0) begin nFails++; $display("[TB] FAIL reset_lockLost got %b want 0", bus.o_lockLost); end
    nChecks++; if (bus.o_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL reset_timeout got %b want 0", bus.o_timeout); end
  endtask

  task automatic test_fill();
    bit valid, b;
    applyStimulus(1, 0, 0, 0, 0);
    nChecks++; if (bus.o_busy !== 1'b1) begin nFails++; $display("[TB] FAIL fill_busy_start got %b want 1", bus.o_busy); end
    for (int c = 0; c < 200 && mK < 24; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      b = bit'((mK + 1) % 2);
      applyStimulus(0, 0, valid, b, 1'b1);
      nChecks++; if (bus.o_window !== expWindow()) begin nFails++; $display("[TB] FAIL fill_window got %h want %h", bus.o_window, expWindow()); end
      nChecks++; if (bus.o_corrStrobe !== (mStrobeK != 0)) begin nFails++; $display("[TB] FAIL fill_strobe got %b want %b (bits %0d)", bus.o_corrStrobe, mStrobeK != 0, mK); end
      nChecks++; if (bus.o_busy !== 1'b1) begin nFails++; $display("[TB] FAIL fill_busy got %b want 1", bus.o_busy); end
      nChecks++; if (bus.o_locked !== mLocked) begin nFails++; $display("[TB] FAIL fill_locked got %b want %b", bus.o_locked, mLocked); end
      if (mStrobeK == W) begin
        nChecks++; if (bus.o_window !== 16'hAAAA) begin nFails++; $display("[TB] FAIL fill_first_window got %h want aaaa", bus.o_window); end
      end
    end
    nChecks++; if (bus.o_lockPhase !== PW'(2)) begin nFails++; $display("[TB] FAIL fill_masking_phase got %0d want 2", bus.o_lockPhase); end
    applyStimulus(0, 1, 0, 0, 0);
    nChecks++; if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL fill_stop_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_lock();
    bit hit, wasTracking, lockSeen;
    int ph, extra, lockK;
    lockSeen = 0; extra = 0; lockK = -1;
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 300 && extra < 16; c++) begin
      ph = pendPhase();
      if (!mTracking) hit = (ph == 5);
      else hit = (ph == 5) ? 1'b1 : bit'($urandom_range(0, 1));
      wasTracking = mTracking;
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), hit);
      nChecks++; if (bus.o_locked !== mLocked) begin nFails++; $display("[TB] FAIL lock_locked got %b want %b (eval bit %0d)", bus.o_locked, mLocked, mLastEvalK); end
      nChecks++; if (bus.o_lockPhase !== PW'(mLockPh)) begin nFails++; $display("[TB] FAIL lock_phase got %0d want %0d", bus.o_lockPhase, mLockPh); end
      nChecks++; if (bus.o_corrStrobe !== (mStrobeK != 0)) begin nFails++; $display("[TB] FAIL lock_strobe got %b want %b", bus.o_corrStrobe, mStrobeK != 0); end
      nChecks++; if (bus.o_lockLost !== 1'b0) begin nFails++; $display("[TB] FAIL lock_lost got %b want 0", bus.o_lockLost); end
      if (!wasTracking && mTracking) begin
        nChecks++; if (bus.o_lockPhase !== PW'(5)) begin nFails++; $display("[TB] FAIL lock_track_phase got %0d want 5", bus.o_lockPhase); end
      end
      if (bus.o_locked === 1'b1 && !lockSeen) begin lockSeen = 1; lockK = mLastEvalK; end
      if (lockSeen) extra++;
    end
    nChecks++; if (lockK !== 38) begin nFails++; $display("[TB] FAIL lock_bit_index got %0d want 38", lockK); end
  endtask

  task automatic test_lost();
    bit hit, done;
    int ph, lostCount;
    done = 0; lostCount = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      ph = pendPhase();
      if (mTracking && mLockPh == 5) hit = (ph != 5) ? bit'($urandom_range(0, 1)) : 1'b0;
      else if (!mTracking) hit = (ph == 2);
      else hit = 1'b1;
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), hit);
      nChecks++; if (bus.o_lockLost !== expLost) begin nFails++; $display("[TB] FAIL lost_pulse got %b want %b", bus.o_lockLost, expLost); end
      nChecks++; if (bus.o_locked !== mLocked) begin nFails++; $display("[TB] FAIL lost_locked got %b want %b", bus.o_locked, mLocked); end
      nChecks++; if (bus.o_lockPhase !== PW'(mLockPh)) begin nFails++; $display("[TB] FAIL lost_phase got %0d want %0d", bus.o_lockPhase, mLockPh); end
      if (bus.o_lockLost === 1'b1) lostCount++;
      if (mTracking && mLockPh == 2) begin
        done = 1;
        nChecks++; if (bus.o_lockPhase !== PW'(2)) begin nFails++; $display("[TB] FAIL lost_new_phase got %0d want 2", bus.o_lockPhase); end
      end
    end
    nChecks++; if (lostCount !== 1) begin nFails++; $display("[TB] FAIL lost_count got %0d want 1", lostCount); end
  endtask

  task automatic test_stop_start();
    for (int c = 0; c < 200 && !mLocked; c++)
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), pendPhase() == 2);
    nChecks++; if (bus.o_locked !== 1'b1) begin nFails++; $display("[TB] FAIL ss_prelock got %b want 1", bus.o_locked); end
    applyStimulus(1, 1, 1, 1'b1, 1'b1);
    nChecks++; if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL ss_busy got %b want 0", bus.o_busy); end
    nChecks++; if (bus.o_locked !== 1'b0) begin nFails++; $display("[TB] FAIL ss_locked got %b want 0", bus.o_locked); end
    nChecks++; if (bus.o_lockLost !== 1'b0) begin nFails++; $display("[TB] FAIL ss_lost got %b want 0", bus.o_lockLost); end
    nChecks++; if (bus.o_corrStrobe !== 1'b0) begin nFails++; $display("[TB] FAIL ss_strobe got %b want 0", bus.o_corrStrobe); end
    applyStimulus(0, 0, 1, 1'b1, 1'b0);
    nChecks++; if (bus.o_window !== '0) begin nFails++; $display("[TB] FAIL ss_idle_window got %h want 0", bus.o_window); end
    nChecks++; if (bus.o_lockLost !== 1'b0) begin nFails++; $display("[TB] FAIL ss_idle_lost got %b want 0", bus.o_lockLost); end
    applyStimulus(1, 0, 0, 0, 0);
    nChecks++; if (bus.o_busy !== 1'b1) begin nFails++; $display("[TB] FAIL ss_restart_busy got %b want 1", bus.o_busy); end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), 1'b1);
      nChecks++; if (bus.o_corrStrobe !== 1'b0) begin nFails++; $display("[TB] FAIL ss_fill_strobe got %b want 0", bus.o_corrStrobe); end
      nChecks++; if (bus.o_window !== expWindow()) begin nFails++; $display("[TB] FAIL ss_fill_window got %h want %h", bus.o_window, expWindow()); end
    end
    applyStimulus(0, 1, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int toCount, toK;
    bit done;
    toCount = 0; toK = -1; done = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 400 && mRunning; c++) begin
      applyStimulus(0, 0, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 1'b0);
      nChecks++; if (bus.o_timeout !== expTimeout) begin nFails++; $display("[TB] FAIL to_pulse got %b want %b", bus.o_timeout, expTimeout); end
      nChecks++; if (bus.o_busy !== mRunning) begin nFails++; $display("[TB] FAIL to_busy got %b want %b", bus.o_busy, mRunning); end
      if (bus.o_timeout === 1'b1) begin toCount++; toK = mLastEvalK; end
    end
    nChecks++; if (toCount !== 1) begin nFails++; $display("[TB] FAIL to_count got %0d want 1", toCount); end
    nChecks++; if (toK !== W + NAVG + SEARCH_LIMIT - 1) begin nFails++; $display("[TB] FAIL to_bit_index got %0d want %0d", toK, W + NAVG + SEARCH_LIMIT - 1); end
    applyStimulus(0, 0, 1, 1'b1, 1'b0);
    nChecks++; if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL to_idle_busy got %b want 0", bus.o_busy); end
    nChecks++; if (bus.o_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL to_idle_pulse got %b want 0", bus.o_timeout); end
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 400 && !done; c++) begin
      applyStimulus(0, 0, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                    mStrobeK == W + NAVG + SEARCH_LIMIT - 1);
      nChecks++; if (bus.o_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL to_late_hit_pulse got %b want 0", bus.o_timeout); end
      if (mLastEvalK == W + NAVG + SEARCH_LIMIT - 1) done = 1;
    end
    nChecks++; if (bus.o_lockPhase !== PW'(1)) begin nFails++; $display("[TB] FAIL to_late_hit_phase got %0d want 1", bus.o_lockPhase); end
    nChecks++; if (bus.o_busy !== 1'b1) begin nFails++; $display("[TB] FAIL to_late_hit_busy got %b want 1", bus.o_busy); end
    applyStimulus(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 300 && !mLocked; c++)
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), pendPhase() == 5);
    nChecks++; if (bus.o_locked !== 1'b1) begin nFails++; $display("[TB] FAIL rm_prelock got %b want 1", bus.o_locked); end
    applyReset();
    nChecks++; if (bus.o_window !== '0) begin nFails++; $display("[TB] FAIL rm_window got %h want 0", bus.o_window); end
    nChecks++; if (bus.o_busy !== 1'b0) begin nFails++; $display("[TB] FAIL rm_busy got %b want 0", bus.o_busy); end
    nChecks++; if (bus.o_locked !== 1'b0) begin nFails++; $display("[TB] FAIL rm_locked got %b want 0", bus.o_locked); end
    nChecks++; if (bus.o_lockPhase !== '0) begin nFails++; $display("[TB] FAIL rm_lockPhase got %0d want 0", bus.o_lockPhase); end
    nChecks++; if (bus.o_corrStrobe !== 1'b0) begin nFails++; $display("[TB] FAIL rm_strobe got %b want 0", bus.o_corrStrobe); end
    nChecks++; if (bus.o_lockLost !== 1'b0) begin nFails++; $display("[TB] FAIL rm_lost got %b want 0", bus.o_lockLost); end
    nChecks++; if (bus.o_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL rm_timeout got %b want 0", bus.o_timeout); end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), 1'b1);
      nChecks++; if (bus.o_window !== '0) begin nFails++; $display("[TB] FAIL rm_idle_window got %h want 0", bus.o_window); end
      nChecks++; if (bus.o_corrStrobe !== 1'b0) begin nFails++; $display("[TB] FAIL rm_idle_strobe got %b want 0", bus.o_corrStrobe); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lock();
    test_lost();
    test_stop_start();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/correlation_sequencer.md
Name: correlation_sequencer

Overview:
- Control block for the correlation datapath (XNOR multiplier, counting filter, correlation shift register, moving average, comparator).
- Builds the SAMPLES*OSF-bit oversampled comparison window from a serial bit stream and issues one enable strobe per new window to the shift register and moving-average stages.
- Masks comparator results until the moving average is primed, then searches for a repeating correlation peak at a fixed oversampling phase.
- Declares lock or loss of lock, and times out if no peak is found.

Parameters:
- SAMPLES, 2, symbols per correlation window
- OSF, 8, oversampling factor (samples per symbol)
- n, 3, moving-average depth; number of warm-up strobes with CorrHit ignored
- LOCK_HITS, 3, peaks at the tracked phase required to assert Locked
- MISS_MAX, 2, consecutive misses at the tracked phase that end tracking
- SEARCH_LIMIT, 64, SEARCH evaluations without a peak before timeout

Ports:
- Clk, in, 1, system clock, all logic on rising edge
- Reset, in, 1, synchronous active-high reset
- Start, in, 1, pulse; begins acquisition from IDLE
- Stop, in, 1, pulse; aborts to IDLE from any state
- BitIn, in, 1, oversampled input bit
- BitValid, in, 1, BitIn valid this cycle; may be high every cycle
- CorrHit, in, 1, comparator output (correlation > moving average)
- Window, out, SAMPLES*OSF, comparison window to datapath DataIn2
- CorrStrobe, out, 1, Enable to shift register and moving average
- Busy, out, 1, high in any state except IDLE
- Locked, out, 1, lock indication
- LockPhase, out, max(1,$clog2(OSF)), tracked oversampling phase
- LockLost, out, 1, one-cycle pulse on loss of lock
- Timeout, out, 1, one-cycle pulse on search timeout

Behaviour:
- Reset: state=IDLE; Window=0; CorrStrobe, Busy, Locked, LockLost, Timeout=0; LockPhase=0; all counters=0. Reset overrides every other input, including mid-operation.
- Let W=SAMPLES*OSF. An accepted bit is BitValid=1 in any state except IDLE.
- Window update: Window <= {Window[W-2:0],BitIn}.
- Phase counter: PhaseCnt increments modulo OSF on each accepted bit. Bit k after Start (1-based) has phase (k-1) mod OSF.
- CorrStrobe is registered. It is high for the single cycle after an accepted bit that shifts the window while in WARMUP, SEARCH or TRACK, so the Window is already updated when it is high.
- Evaluation: CorrHit is sampled on the edge that ends a CorrStrobe cycle. That cycle's phase is the strobe's bit phase, which is held in a register alongside CorrStrobe.
- Stop has priority over Start and over all other transitions. Start outside IDLE is ignored. BitValid in IDLE is ignored.
- IDLE:
  - Start -> FILL.
  - Clear Window, PhaseCnt and all counters. Locked=0.
- FILL:
  - Shift on each accepted bit, no strobe.
  - The accepted bit that makes the fill count equal W also strobes and enters WARMUP with warm-up count 1.
- WARMUP:
  - Each accepted bit strobes. CorrHit is ignored for the first n strobes, i.e. bits W..W+n-1.
  - The state becomes SEARCH after the n-th strobe is issued.
- SEARCH:
  - Each evaluation increments the search count.
  - CorrHit=1: LockPhase <= strobe phase; hit count=1, miss count=0; -> TRACK.
  - If the search count reaches SEARCH_LIMIT with no hit: Timeout pulse -> IDLE.
  - A hit on the SEARCH_LIMIT-th evaluation wins over the timeout.
- TRACK:
  - Only evaluations whose phase equals LockPhase count; all others are ignored.
  - Hit: hit count++ (saturating); miss count=0. Locked <= 1 when the hit count reaches LOCK_HITS.
  - Miss: miss count++.
  - When the miss count reaches MISS_MAX:
    - If Locked: LockLost pulse, Locked <= 0.
    - Then -> SEARCH with search count=0 in either case.
- Locked changes only in TRACK, on a transition to IDLE (cleared), or on reset.
- Counters are sized to hold their limits; no wrap-around before the limit is reached.

Test Plan:
- Reset mid-TRACK with Locked=1 -> next cycle: all outputs 0, Busy=0; 20 BitValid without Start -> Window stays 0, no CorrStrobe.
- Start, then BitValid every cycle with BitIn alternating -> first CorrStrobe follows bit 16 (Window=16'h5555 or 16'hAAAA); strobes after bits 16-18 ignore a forced CorrHit=1; Busy=1 throughout.
- After warm-up, CorrHit=1 only on phase-5 evaluations -> TRACK at the first phase-5 evaluation (LockPhase=5); Locked=1 after the third phase-5 hit; Locked unaffected by hits at other phases.
- Locked at phase 5, then CorrHit=0 on two consecutive phase-5 evaluations -> single-cycle LockLost pulse, Locked=0, SEARCH; a phase-2 hit then gives LockPhase=2.
- CorrHit held 0 after warm-up -> Timeout pulse on the 64th SEARCH evaluation, then IDLE, Busy=0; repeat with CorrHit=1 on the 64th evaluation -> TRACK, no Timeout.
- Start and Stop asserted in the same cycle during TRACK -> IDLE, Locked=0, no LockLost pulse; next lone Start -> FILL.
